// File: rtl/sram_rw_array_if.sv
//------------------------------------------------------------------------------
// sram_rw_array_if
//
// Request/response bundle between the digital request logic and the
// sram_rw_array controller. The write and read ports are independent.
//
//   master : request side (drives wr_req/wr_addr/wr_data, rd_req/rd_addr)
//   slave  : the array controller (drives wr_ack, rd_valid, rd_data, busy)
//
// Signals:
//   wr_req      write request (level)        wr_ack    write committed pulse
//   wr_addr     write row                    rd_valid  rd_data valid pulse
//   wr_data     write word                   rd_data   sensed word (held)
//   rd_req      read request (level)         busy      either FSM not idle
//   rd_addr     read row
//
// Optional (macro SRAM_PARITY_EN defined):
//   wr_par_flip invert the stored parity bit of this write
//   rd_perr     parity mismatch flag, qualified by rd_valid
//------------------------------------------------------------------------------
interface sram_rw_array_if #(
    parameter int ADDR_W = 4,
    parameter int COLS   = 8
);
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [COLS-1:0]   wr_data;
    logic              wr_ack;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_valid;
    logic [COLS-1:0]   rd_data;
    logic              busy;
`ifdef SRAM_PARITY_EN
    logic              wr_par_flip;
    logic              rd_perr;
`endif

    modport master (
        output wr_req, wr_addr, wr_data, rd_req, rd_addr,
`ifdef SRAM_PARITY_EN
        output wr_par_flip,
        input  rd_perr,
`endif
        input  wr_ack, rd_valid, rd_data, busy
    );

    modport slave (
        input  wr_req, wr_addr, wr_data, rd_req, rd_addr,
`ifdef SRAM_PARITY_EN
        input  wr_par_flip,
        output rd_perr,
`endif
        output wr_ack, rd_valid, rd_data, busy
    );
endinterface

// File: rtl/sram_rw_array.sv
//------------------------------------------------------------------------------
// sram_rw_array
//
// Behavioural model of an array of SRAM cells with separate write and read
// ports, plus the clocked controller that sequences them. The write port
// drives the write bitlines/wordline for WR_CYC cycles and commits the row.
// The read port precharges per-column bitline pairs (integer mV), opens the
// wordline so the side storing 0 discharges, and resolves each column with a
// differential compare. Both ports run independently and concurrently.
//
// Ports:
//   clk    clock, all state updates on the rising edge
//   rst_n  synchronous active-low reset
//   bus    sram_rw_array_if.slave (write/read request and response signals)
//
// Optional feature macro: SRAM_PARITY_EN
//   Defined   : each row also stores an even-parity bit; bus.wr_par_flip
//               inverts it at acceptance, bus.rd_perr flags a mismatch.
//   Undefined : no parity storage; timing is identical.
//------------------------------------------------------------------------------
module sram_rw_array #(
    parameter int ROWS     = 16,
    parameter int COLS     = 8,
    parameter int ADDR_W   = 4,
    parameter int WR_CYC   = 2,
    parameter int PRE_CYC  = 1,
    parameter int WL_CYC   = 4,
    parameter int VDD_MV   = 1500,
    parameter int DROP_MV  = 100,
    parameter int SENSE_MV = 250
) (
    input  logic           clk,
    input  logic           rst_n,
    sram_rw_array_if.slave bus
);

    // One counter width serves all three phase counters (each counts 0..CYC-1).
    localparam int CNT_MAX = (WR_CYC > PRE_CYC)
                           ? ((WR_CYC > WL_CYC) ? WR_CYC : WL_CYC)
                           : ((PRE_CYC > WL_CYC) ? PRE_CYC : WL_CYC);
    localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t WR_LAST  = cnt_t'(WR_CYC - 1);
    localparam cnt_t PRE_LAST = cnt_t'(PRE_CYC - 1);
    localparam cnt_t WL_LAST  = cnt_t'(WL_CYC - 1);
    localparam cnt_t CNT_ONE  = cnt_t'(1);

    typedef enum logic [1:0] {
        W_IDLE,
        W_DRIVE,
        W_ACK
    } w_state_e;

    typedef enum logic [1:0] {
        R_IDLE,
        R_PRE,
        R_WL,
        R_SENSE
    } r_state_e;

    // Saturating discharge of one bitline by one wordline cycle.
    function automatic int sat_drop(input int mv);
        return (mv > DROP_MV) ? (mv - DROP_MV) : 0;
    endfunction

    function automatic int abs_diff(input int a, input int b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    //--------------------------------------------------------------------------
    // Cell array
    //--------------------------------------------------------------------------
    // NOTE: the storage array is deliberately left out of reset; it only has a
    // power-up value, so a reset never disturbs stored data.
    logic [COLS-1:0] mem_q [ROWS] = '{default: '0};
`ifdef SRAM_PARITY_EN
    logic            par_mem_q [ROWS] = '{default: 1'b0};
`endif

    //--------------------------------------------------------------------------
    // Write port
    //--------------------------------------------------------------------------
    w_state_e          w_state_q, w_state_d;
    cnt_t              w_cnt_q, w_cnt_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [COLS-1:0]   wr_data_q, wr_data_d;
    logic              mem_we;
    logic              wr_in_range;
`ifdef SRAM_PARITY_EN
    logic              wr_par_q, wr_par_d;
`endif

    assign wr_in_range = (int'(wr_addr_q) < ROWS);

    // NOTE: every output of a combinational block gets a default before the
    // case statement, so no path leaves a variable unassigned (no latches).
    always_comb begin
        w_state_d = w_state_q;
        w_cnt_d   = w_cnt_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        mem_we    = 1'b0;
`ifdef SRAM_PARITY_EN
        wr_par_d  = wr_par_q;
`endif
        case (w_state_q)
            W_IDLE: begin
                if (bus.wr_req) begin
                    wr_addr_d = bus.wr_addr;
                    wr_data_d = bus.wr_data;
`ifdef SRAM_PARITY_EN
                    wr_par_d  = (^bus.wr_data) ^ bus.wr_par_flip;
`endif
                    w_cnt_d   = '0;
                    w_state_d = W_DRIVE;
                end
            end
            W_DRIVE: begin
                if (w_cnt_q == WR_LAST) begin
                    // Out-of-range rows are dropped but still acknowledged.
                    mem_we    = wr_in_range;
                    w_state_d = W_ACK;
                end else begin
                    w_cnt_d = w_cnt_q + CNT_ONE;
                end
            end
            W_ACK:   w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_state_q <= W_IDLE;
            w_cnt_q   <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
`ifdef SRAM_PARITY_EN
            wr_par_q  <= 1'b0;
`endif
        end else begin
            w_state_q <= w_state_d;
            w_cnt_q   <= w_cnt_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
`ifdef SRAM_PARITY_EN
            wr_par_q  <= wr_par_d;
`endif
        end
    end

    // A reset arriving on the commit edge aborts the write.
    always_ff @(posedge clk) begin
        if (rst_n && mem_we) begin
            mem_q[wr_addr_q] <= wr_data_q;
`ifdef SRAM_PARITY_EN
            par_mem_q[wr_addr_q] <= wr_par_q;
`endif
        end
    end

    //--------------------------------------------------------------------------
    // Read port
    //--------------------------------------------------------------------------
    r_state_e          r_state_q, r_state_d;
    cnt_t              r_cnt_q, r_cnt_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [COLS-1:0]   snap_q, snap_d;
    int                bl_q [COLS];
    int                bl_d [COLS];
    int                blb_q [COLS];
    int                blb_d [COLS];
    logic [COLS-1:0]   rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              all_sensed;
    logic              rd_in_range;
    logic [COLS-1:0]   rd_row;
`ifdef SRAM_PARITY_EN
    logic              snap_par_q, snap_par_d;
    logic              rd_perr_q, rd_perr_d;
    logic              rd_row_par;
`endif

    assign rd_in_range = (int'(rd_addr_q) < ROWS);
    // Out-of-range reads snapshot an all-zero row and so sense all zeros.
    assign rd_row      = rd_in_range ? mem_q[rd_addr_q] : '0;
`ifdef SRAM_PARITY_EN
    assign rd_row_par  = rd_in_range ? par_mem_q[rd_addr_q] : 1'b0;
`endif

    always_comb begin
        r_state_d  = r_state_q;
        r_cnt_d    = r_cnt_q;
        rd_addr_d  = rd_addr_q;
        snap_d     = snap_q;
        bl_d       = bl_q;
        blb_d      = blb_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        all_sensed = 1'b1;
`ifdef SRAM_PARITY_EN
        snap_par_d = snap_par_q;
        rd_perr_d  = 1'b0;
`endif
        case (r_state_q)
            R_IDLE: begin
                if (bus.rd_req) begin
                    rd_addr_d = bus.rd_addr;
                    r_cnt_d   = '0;
                    r_state_d = R_PRE;
                end
            end
            R_PRE: begin
                bl_d  = '{default: VDD_MV};
                blb_d = '{default: VDD_MV};
                if (r_cnt_q == PRE_LAST) begin
                    // Row is captured on the edge entering R_WL; a commit on
                    // that same edge is therefore not visible to this read.
                    snap_d    = rd_row;
`ifdef SRAM_PARITY_EN
                    snap_par_d = rd_row_par;
`endif
                    r_cnt_d   = '0;
                    r_state_d = R_WL;
                end else begin
                    r_cnt_d = r_cnt_q + CNT_ONE;
                end
            end
            R_WL: begin
                // The side holding 0 discharges; exit once every column has
                // developed enough differential, or at the cycle limit.
                for (int c = 0; c < COLS; c++) begin
                    if (snap_q[c]) begin
                        blb_d[c] = sat_drop(blb_q[c]);
                    end else begin
                        bl_d[c] = sat_drop(bl_q[c]);
                    end
                    if (abs_diff(bl_d[c], blb_d[c]) < SENSE_MV) begin
                        all_sensed = 1'b0;
                    end
                end
                if (all_sensed || (r_cnt_q == WL_LAST)) begin
                    r_state_d = R_SENSE;
                end else begin
                    r_cnt_d = r_cnt_q + CNT_ONE;
                end
            end
            R_SENSE: begin
                // A column with no differential keeps its previous bit.
                for (int c = 0; c < COLS; c++) begin
                    if (bl_q[c] > blb_q[c]) begin
                        rd_data_d[c] = 1'b1;
                    end else if (bl_q[c] < blb_q[c]) begin
                        rd_data_d[c] = 1'b0;
                    end
                end
                rd_valid_d = 1'b1;
`ifdef SRAM_PARITY_EN
                rd_perr_d  = (^rd_data_d) ^ snap_par_q;
`endif
                r_state_d  = R_IDLE;
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state_q  <= R_IDLE;
            r_cnt_q    <= '0;
            rd_addr_q  <= '0;
            snap_q     <= '0;
            bl_q       <= '{default: VDD_MV};
            blb_q      <= '{default: VDD_MV};
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
`ifdef SRAM_PARITY_EN
            snap_par_q <= 1'b0;
            rd_perr_q  <= 1'b0;
`endif
        end else begin
            r_state_q  <= r_state_d;
            r_cnt_q    <= r_cnt_d;
            rd_addr_q  <= rd_addr_d;
            snap_q     <= snap_d;
            bl_q       <= bl_d;
            blb_q      <= blb_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
`ifdef SRAM_PARITY_EN
            snap_par_q <= snap_par_d;
            rd_perr_q  <= rd_perr_d;
`endif
        end
    end

    //--------------------------------------------------------------------------
    // Outputs
    //--------------------------------------------------------------------------
    assign bus.wr_ack   = (w_state_q == W_ACK);
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = rd_data_q;
    assign bus.busy     = (w_state_q != W_IDLE) || (r_state_q != R_IDLE);
`ifdef SRAM_PARITY_EN
    assign bus.rd_perr  = rd_perr_q;
`endif

endmodule

// File: tb/tb_sram_rw_array.sv
//------------------------------------------------------------------------------
// tb_sram_rw_array
//
// Three sram_rw_array instances share one stimulus stream:
//   v0: defaults (DROP_MV=100)
//   v1: ROWS=12, DROP_MV=50 (wordline runs to its limit, rows 12..15 absent)
//   v2: DROP_MV=0 (no differential; reads hold the previous value)
// A reference model keeps the row contents per instance and derives the
// expected latency and read data from the timing rules of the block.
// Optional macro: SRAM_PARITY_EN (also checks rd_perr).
//------------------------------------------------------------------------------
module tb_sram_rw_array;

    localparam int NV       = 3;
    localparam int WR_CYC   = 2;
    localparam int PRE_CYC  = 1;
    localparam int WL_CYC   = 4;
    localparam int SENSE_MV = 250;

    logic       clk;
    logic       rst_n;
    logic       wr_req;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       rd_req;
    logic [3:0] rd_addr;

    int n_checks = 0;
    int n_pass   = 0;

    sram_rw_array_if #(.ADDR_W(4), .COLS(8)) if0 ();
    sram_rw_array_if #(.ADDR_W(4), .COLS(8)) if1 ();
    sram_rw_array_if #(.ADDR_W(4), .COLS(8)) if2 ();

    sram_rw_array dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    sram_rw_array #(.ROWS(12), .DROP_MV(50)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    sram_rw_array #(.DROP_MV(0)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

    assign if0.wr_req  = wr_req;   assign if1.wr_req  = wr_req;   assign if2.wr_req  = wr_req;
    assign if0.wr_addr = wr_addr;  assign if1.wr_addr = wr_addr;  assign if2.wr_addr = wr_addr;
    assign if0.wr_data = wr_data;  assign if1.wr_data = wr_data;  assign if2.wr_data = wr_data;
    assign if0.rd_req  = rd_req;   assign if1.rd_req  = rd_req;   assign if2.rd_req  = rd_req;
    assign if0.rd_addr = rd_addr;  assign if1.rd_addr = rd_addr;  assign if2.rd_addr = rd_addr;

    logic [2:0] ack_v, val_v, busy_v;
    logic [7:0] dat_v [NV];
    assign ack_v  = {if2.wr_ack,   if1.wr_ack,   if0.wr_ack};
    assign val_v  = {if2.rd_valid, if1.rd_valid, if0.rd_valid};
    assign busy_v = {if2.busy,     if1.busy,     if0.busy};
    assign dat_v[0] = if0.rd_data;
    assign dat_v[1] = if1.rd_data;
    assign dat_v[2] = if2.rd_data;

`ifdef SRAM_PARITY_EN
    logic       wr_par_flip;
    logic [2:0] perr_v;
    assign if0.wr_par_flip = wr_par_flip;
    assign if1.wr_par_flip = wr_par_flip;
    assign if2.wr_par_flip = wr_par_flip;
    assign perr_v = {if2.rd_perr, if1.rd_perr, if0.rd_perr};
    int par_m [NV][16];
`endif

    // Reference model state: row contents and last sensed word per instance.
    int mem_m  [NV][16];
    int prev_m [NV];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int rows_of(input int v);
        return (v == 1) ? 12 : 16;
    endfunction

    function automatic int drop_of(input int v);
        case (v)
            0:       return 100;
            1:       return 50;
            default: return 0;
        endcase
    endfunction

    // Wordline cycles: ceil(SENSE/DROP) capped at WL_CYC; no drop -> the cap.
    function automatic int wl_cycles(input int v);
        int n;
        if (drop_of(v) == 0) return WL_CYC;
        n = (SENSE_MV + drop_of(v) - 1) / drop_of(v);
        return (n < WL_CYC) ? n : WL_CYC;
    endfunction

    function automatic int parity8(input int x);
        logic [7:0] b;
        b = 8'(x);
        return int'(^b);
    endfunction

    // Optional write accepted at edge 0, optional read accepted at edge r_delay.
    task automatic run_ops(input string tag,
                           input bit do_w, input int wa, input int wd, input bit flip,
                           input bit do_r, input int ra, input int r_delay);
        int ack_cnt [NV];
        int ack_cyc [NV];
        int val_cnt [NV];
        int val_cyc [NV];
        int val_dat [NV];
        int exp_dat [NV];
        int exp_busy0;
`ifdef SRAM_PARITY_EN
        int val_perr [NV];
        int exp_perr [NV];
`endif
        for (int v = 0; v < NV; v++) begin
            int word;
            int par;
            word = 0;
            par  = 0;
            if (ra < rows_of(v)) begin
                word = mem_m[v][ra];
`ifdef SRAM_PARITY_EN
                par  = par_m[v][ra];
`endif
            end
            // A commit strictly before the wordline-entry edge is visible.
            if (do_w && do_r && wa == ra && wa < rows_of(v) && WR_CYC < r_delay + PRE_CYC) begin
                word = wd;
                par  = parity8(wd) ^ int'(flip);
            end
            exp_dat[v] = (drop_of(v) == 0) ? prev_m[v] : word;
`ifdef SRAM_PARITY_EN
            exp_perr[v] = parity8(exp_dat[v]) ^ par;
            val_perr[v] = -1;
`endif
            ack_cnt[v] = 0;
            ack_cyc[v] = -1;
            val_cnt[v] = 0;
            val_cyc[v] = -1;
            val_dat[v] = -1;
        end
        exp_busy0 = (do_w || (do_r && r_delay == 0)) ? 7 : 0;

        wr_req  = do_w;
        wr_addr = 4'(wa);
        wr_data = 8'(wd);
`ifdef SRAM_PARITY_EN
        wr_par_flip = flip;
`endif
        rd_addr = 4'(ra);
        rd_req  = do_r && (r_delay == 0);
        for (int c = 0; c < 16; c++) begin
            @(posedge clk);
            #1;
            wr_req = 1'b0;
            rd_req = do_r && (c + 1 == r_delay);
            if (c == 0) check({tag, " busy_after_accept"}, 32'(busy_v), exp_busy0);
            for (int v = 0; v < NV; v++) begin
                if (ack_v[v]) begin
                    ack_cnt[v]++;
                    ack_cyc[v] = c;
                end
                if (val_v[v]) begin
                    val_cnt[v]++;
                    val_cyc[v] = c;
                    val_dat[v] = int'(dat_v[v]);
`ifdef SRAM_PARITY_EN
                    val_perr[v] = int'(perr_v[v]);
`endif
                end
            end
        end

        for (int v = 0; v < NV; v++) begin
            check($sformatf("%s v%0d ack_count", tag, v), ack_cnt[v], do_w ? 1 : 0);
            if (do_w) check($sformatf("%s v%0d ack_cycle", tag, v), ack_cyc[v], WR_CYC);
            check($sformatf("%s v%0d valid_count", tag, v), val_cnt[v], do_r ? 1 : 0);
            if (do_r) begin
                check($sformatf("%s v%0d valid_cycle", tag, v), val_cyc[v],
                      r_delay + PRE_CYC + wl_cycles(v) + 1);
                check($sformatf("%s v%0d rd_data", tag, v), val_dat[v], exp_dat[v]);
`ifdef SRAM_PARITY_EN
                check($sformatf("%s v%0d rd_perr", tag, v), val_perr[v], exp_perr[v]);
`endif
            end
        end
        check({tag, " busy_idle"}, 32'(busy_v), 0);

        for (int v = 0; v < NV; v++) begin
            if (do_w && wa < rows_of(v)) begin
                mem_m[v][wa] = wd;
`ifdef SRAM_PARITY_EN
                par_m[v][wa] = parity8(wd) ^ int'(flip);
`endif
            end
            if (do_r) prev_m[v] = exp_dat[v];
        end
    endtask

    task automatic write_row(input string tag, input int wa, input int wd);
        run_ops(tag, 1'b1, wa, wd, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic read_row(input string tag, input int ra);
        run_ops(tag, 1'b0, 0, 0, 1'b0, 1'b1, ra, 0);
    endtask

    // Reset lands on the edge that would have committed the write.
    task automatic reset_mid_write(input int wa, input int wd);
        int acks;
        acks    = 0;
        wr_req  = 1'b1;
        wr_addr = 4'(wa);
        wr_data = 8'(wd);
        @(posedge clk); #1;
        wr_req = 1'b0;
        @(posedge clk); #1;
        if (ack_v != 3'b000) acks++;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("rst_wr busy", 32'(busy_v), 0);
        for (int c = 0; c < 6; c++) begin
            if (ack_v != 3'b000) acks++;
            @(posedge clk); #1;
        end
        check("rst_wr no_ack", acks, 0);
        for (int v = 0; v < NV; v++) prev_m[v] = 0;
    endtask

    // Reset lands while the wordline is open.
    task automatic reset_mid_read(input int ra);
        int vals;
        vals    = 0;
        rd_req  = 1'b1;
        rd_addr = 4'(ra);
        @(posedge clk); #1;
        rd_req = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("rst_rd busy", 32'(busy_v), 0);
        check("rst_rd valid", 32'(val_v), 0);
        for (int v = 0; v < NV; v++) begin
            check($sformatf("rst_rd v%0d rd_data", v), 32'(dat_v[v]), 0);
            prev_m[v] = 0;
        end
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (val_v != 3'b000) vals++;
        end
        check("rst_rd no_valid", vals, 0);
    endtask

    initial begin
        for (int v = 0; v < NV; v++) begin
            prev_m[v] = 0;
            for (int r = 0; r < 16; r++) begin
                mem_m[v][r] = 0;
`ifdef SRAM_PARITY_EN
                par_m[v][r] = 0;
`endif
            end
        end
        rst_n   = 1'b0;
        wr_req  = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        rd_req  = 1'b0;
        rd_addr = '0;
`ifdef SRAM_PARITY_EN
        wr_par_flip = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("reset ack", 32'(ack_v), 0);
        check("reset valid", 32'(val_v), 0);
        check("reset busy", 32'(busy_v), 0);
        check("reset rd_data v0", 32'(dat_v[0]), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic write then read.
        write_row("wr_a5", 3, 'hA5);
        read_row("rd_a5", 3);

        // Overwrite, then a never-written row.
        write_row("wr_ff", 0, 'hFF);
        write_row("wr_00", 0, 'h00);
        read_row("rd_row0", 0);
        read_row("rd_row7", 7);
        read_row("rd_a5_again", 3);

        // Collision: commit on the wordline-entry edge, then one edge earlier.
        write_row("wr_11a", 5, 'h11);
        run_ops("coll_same", 1'b1, 5, 'h3C, 1'b0, 1'b1, 5, 1);
        write_row("wr_11b", 5, 'h11);
        run_ops("coll_early", 1'b1, 5, 'h3C, 1'b0, 1'b1, 5, 2);

        // Row 13 is out of range for the ROWS=12 instance.
        write_row("wr_oor", 13, 'h77);
        read_row("rd_oor", 13);

        // Resets in flight.
        read_row("rd_pre_rst", 3);
        reset_mid_read(3);
        reset_mid_write(3, 'h5A);
        read_row("rd_after_rst", 3);

        // Parity flip and repair (parity only observed with the macro).
        run_ops("par_flip", 1'b1, 9, 'h01, 1'b1, 1'b0, 0, 0);
        read_row("rd_par_flip", 9);
        run_ops("par_ok", 1'b1, 9, 'h01, 1'b0, 1'b0, 0, 0);
        read_row("rd_par_ok", 9);

        // Random concurrent traffic.
        for (int i = 0; i < 80; i++) begin
            bit do_w;
            bit do_r;
            do_w = ($urandom_range(0, 3) != 0);
            do_r = ($urandom_range(0, 3) != 0);
            run_ops($sformatf("rnd%0d", i), do_w, int'($urandom_range(0, 15)),
                    int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                    do_r, int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
